// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the single register-file write port between the in-order pipeline
//   writeback and a long-latency multiply/divide unit (MDU). All write-port
//   outputs and stall_pipe are registered. A granted request in cycle N appears
//   on wr_* in cycle N+1.
//
//   An MDU result that loses to the pipeline goes into a one-entry hold buffer.
//   A starvation counter forces a pipeline stall so that the held entry
//   eventually drains.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   pipe_w/pipe_addr/pipe_data pipeline writeback request (addr 0 = no request)
//   mdu_valid/addr/data        MDU result. Held stable while mdu_ready=0.
//   mdu_ready                  MDU result accepted this cycle (hold buffer empty)
//   wr_en/wr_addr/wr_data      register-file write port (registered)
//   stall_pipe                 freeze the pipeline to force an MDU slot (registered)
//   pend_valid/pend_addr       hold buffer occupancy and destination, for hazard checks
//   conflict_cnt               pipe-vs-MDU conflict count
//
// Configuration
//   WB_ARB_STATS_EN  when defined, builds the saturating conflict counter.
//                    Otherwise conflict_cnt is tied to 0.

module rf_wport_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 4   // 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_w,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_addr,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              stall_pipe,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr,
    output logic [31:0]       conflict_cnt
);

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {StEmpty, StHeld, StForce} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              stall_q, stall_d;

    logic pipe_req;
    logic mdu_xfer;
    logic mdu_keep;

    // A write to register 0 does nothing, so it is not treated as a request.
    assign pipe_req  = pipe_w & (pipe_addr != '0);
    assign mdu_ready = (state_q == StEmpty);
    assign mdu_xfer  = mdu_valid & mdu_ready;
    // An MDU result for register 0 is accepted and discarded.
    assign mdu_keep  = mdu_xfer & (mdu_addr != '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        // The pipeline always wins when it has a real request.
        if (pipe_req) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pipe_addr;
            wr_data_d = pipe_data;
        end

        case (state_q)
            StEmpty: begin
                if (mdu_keep) begin
                    if (pipe_req) begin
                        hold_addr_d = mdu_addr;
                        hold_data_d = mdu_data;
                        cnt_d       = 4'd1;
                        // The capture cycle already counts as one lost cycle.
                        state_d     = (Limit <= 4'd1) ? StForce : StHeld;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = mdu_addr;
                        wr_data_d = mdu_data;
                    end
                end
            end
            StHeld, StForce: begin
                if (pipe_req) begin
                    cnt_d = (cnt_q < Limit) ? cnt_q + 4'd1 : cnt_q;
                    if (cnt_d >= Limit) begin
                        state_d = StForce;
                    end
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = hold_addr_q;
                    wr_data_d = hold_data_q;
                    cnt_d     = 4'd0;
                    state_d   = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase

        stall_d = (state_d == StForce);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StEmpty;
            cnt_q       <= 4'd0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            stall_q     <= stall_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign stall_pipe = stall_q;
    assign pend_valid = (state_q != StEmpty);
    assign pend_addr  = pend_valid ? hold_addr_q : '0;

`ifdef WB_ARB_STATS_EN
    logic [31:0] conflict_q, conflict_d;

    // Counts only MDU results that actually compete for the port (addr != 0).
    always_comb begin
        conflict_d = conflict_q;
        if (pipe_req && (state_q != StEmpty || mdu_keep) && conflict_q != 32'hFFFF_FFFF) begin
            conflict_d = conflict_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_q <= 32'd0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
module tb_rf_wport_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_w;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        stall_pipe;
    logic        pend_valid;
    logic [4:0]  pend_addr;
    logic [31:0] conflict_cnt;

    rf_wport_arbiter #(
        .DATA_W      (32),
        .ADDR_W      (5),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pipe_w      (pipe_w),
        .pipe_addr   (pipe_addr),
        .pipe_data   (pipe_data),
        .mdu_valid   (mdu_valid),
        .mdu_addr    (mdu_addr),
        .mdu_data    (mdu_data),
        .mdu_ready   (mdu_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .stall_pipe  (stall_pipe),
        .pend_valid  (pend_valid),
        .pend_addr   (pend_addr),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: hold buffer as a queue of {addr,data}, plus a lost-cycle tally.
    logic [36:0] hq[$];
    int          lost;
    bit          forced;
    logic        exp_wr_en;
    logic [4:0]  exp_wr_addr;
    logic [31:0] exp_wr_data;
    longint      exp_conf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        lost        = 0;
        forced      = 1'b0;
        exp_wr_en   = 1'b0;
        exp_wr_addr = '0;
        exp_wr_data = '0;
        exp_conf    = 0;
    endtask

    task automatic model_step(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md);
        bit          ready = (hq.size() == 0);
        bit          preq  = pw && (pa != 0);
        bit          mreal = mv && ready && (ma != 0);
        logic [36:0] h;
`ifdef WB_ARB_STATS_EN
        if (preq && (!ready || mreal) && exp_conf < 64'hFFFF_FFFF) exp_conf++;
`endif
        exp_wr_en = 1'b0;
        if (preq) begin
            exp_wr_en   = 1'b1;
            exp_wr_addr = pa;
            exp_wr_data = pd;
            if (!ready) begin
                lost++;
            end else if (mreal) begin
                hq.push_back({ma, md});
                lost = 1;
            end
            if (hq.size() != 0 && lost >= LIMIT) forced = 1'b1;
        end else if (!ready) begin
            h           = hq.pop_front();
            exp_wr_en   = 1'b1;
            exp_wr_addr = h[36:32];
            exp_wr_data = h[31:0];
            lost        = 0;
            forced      = 1'b0;
        end else if (mreal) begin
            exp_wr_en   = 1'b1;
            exp_wr_addr = ma;
            exp_wr_data = md;
        end
    endtask

    task automatic check_all();
        check("wr_en", 64'(wr_en), 64'(exp_wr_en));
        check("wr_addr", 64'(wr_addr), 64'(exp_wr_addr));
        check("wr_data", 64'(wr_data), 64'(exp_wr_data));
        check("stall_pipe", 64'(stall_pipe), 64'(forced));
        check("mdu_ready", 64'(mdu_ready), 64'(hq.size() == 0));
        check("pend_valid", 64'(pend_valid), 64'(hq.size() != 0));
        check("pend_addr", 64'(pend_addr), (hq.size() != 0) ? 64'(hq[0][36:32]) : 64'd0);
        check("conflict_cnt", 64'(conflict_cnt), 64'(exp_conf));
    endtask

    // Entered at a negedge: check, drive, advance the model, move to the next negedge.
    task automatic cycle(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        check_all();
        pipe_w    = pw;
        pipe_addr = pa;
        pipe_data = pd;
        mdu_valid = mv;
        mdu_addr  = ma;
        mdu_data  = md;
        model_step(pw, pa, pd, mv, ma, md);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit          stuck;
        bit          rdy;
        logic        pw, mv;
        logic [4:0]  pa, ma;
        logic [31:0] pd, md;

        reset     = 1'b0;
        pipe_w    = 1'b0;
        pipe_addr = '0;
        pipe_data = '0;
        mdu_valid = 1'b0;
        mdu_addr  = '0;
        mdu_data  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b1;

        // Pipeline write appears one cycle later.
        cycle(1, 5'd3, 32'h1234, 0, 5'd0, 32'h0);
        check("pipe_wr_addr", 64'(wr_addr), 64'd3);
        check("pipe_wr_data", 64'(wr_data), 64'h1234);
        check("pipe_mdu_ready", 64'(mdu_ready), 64'd1);

        // MDU alone goes straight to the port.
        cycle(0, 5'd0, 32'h0, 1, 5'd5, 32'hDEAD);
        check("mdu_wr_addr", 64'(wr_addr), 64'd5);
        check("mdu_wr_data", 64'(wr_data), 64'hDEAD);
        check("mdu_pend", 64'(pend_valid), 64'd0);

        // Conflict: pipe first, MDU held, then drained.
        cycle(1, 5'd3, 32'hAAAA, 1, 5'd7, 32'hBEEF);
        check("conf_pend_valid", 64'(pend_valid), 64'd1);
        check("conf_pend_addr", 64'(pend_addr), 64'd7);
        check("conf_ready", 64'(mdu_ready), 64'd0);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        check("drain_wr_addr", 64'(wr_addr), 64'd7);
        check("drain_wr_data", 64'(wr_data), 64'hBEEF);
        check("drain_pend", 64'(pend_valid), 64'd0);

        // Starvation: four lost cycles then stall.
        cycle(1, 5'd3, 32'h1, 1, 5'd9, 32'hC0DE);
        cycle(1, 5'd4, 32'h2, 0, 5'd0, 32'h0);
        cycle(1, 5'd5, 32'h3, 0, 5'd0, 32'h0);
        check("starve_no_stall_yet", 64'(stall_pipe), 64'd0);
        cycle(1, 5'd6, 32'h4, 0, 5'd0, 32'h0);
        check("starve_stall", 64'(stall_pipe), 64'd1);
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        check("starve_wr_addr", 64'(wr_addr), 64'd9);
        check("starve_wr_data", 64'(wr_data), 64'hC0DE);
        check("starve_release", 64'(stall_pipe), 64'd0);

        // Register 0 handling.
        cycle(0, 5'd0, 32'h0, 1, 5'd0, 32'h5555);
        check("r0_mdu_wr_en", 64'(wr_en), 64'd0);
        check("r0_mdu_ready", 64'(mdu_ready), 64'd1);
        cycle(1, 5'd0, 32'h1111, 1, 5'd9, 32'h9999);
        check("r0_pipe_wr_addr", 64'(wr_addr), 64'd9);
        check("r0_pipe_wr_data", 64'(wr_data), 64'h9999);

        // Asynchronous reset while holding an entry.
        cycle(1, 5'd3, 32'h7777, 1, 5'd6, 32'h6666);
        pipe_w    = 1'b0;
        mdu_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_wr_en", 64'(wr_en), 64'd0);
        check("arst_wr_addr", 64'(wr_addr), 64'd0);
        check("arst_stall", 64'(stall_pipe), 64'd0);
        check("arst_pend", 64'(pend_valid), 64'd0);
        check("arst_ready", 64'(mdu_ready), 64'd1);
        check("arst_conflict", 64'(conflict_cnt), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cycle(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        check("arst_no_held_write", 64'(wr_en), 64'd0);

        // Randomized traffic; MDU keeps its request stable until accepted.
        stuck = 1'b0;
        mv    = 1'b0;
        ma    = '0;
        md    = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!stuck) begin
                mv = ($urandom_range(0, 2) == 0);
                ma = 5'($urandom_range(0, 12));
                md = $urandom;
            end
            if (forced)      pw = ($urandom_range(0, 7) == 0);
            else if (i < 1500) pw = $urandom_range(0, 1) == 1;
            else             pw = ($urandom_range(0, 9) != 0);
            pa  = 5'($urandom_range(0, 12));
            pd  = $urandom;
            rdy = (hq.size() == 0);
            cycle(pw, pa, pd, mv, ma, md);
            stuck = mv && !rdy;
        end
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
